// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to CDB_WIDTH finished FUs per cycle onto the CDB using
// fixed category priority, per-category round-robin and starvation boosting.
module cdb_arbiter #(
    parameter int NUM_ALU = 8,
    parameter int NUM_LS = 4,
    parameter int NUM_MULT = 4,
    parameter int NUM_BEQ = 4,
    parameter int CDB_WIDTH = 2,
    parameter int STARVE_LIMIT = 7,
    localparam int FU_SIZE = NUM_ALU + NUM_LS + NUM_MULT + NUM_BEQ,
    localparam int FU_IDX_W = $clog2(FU_SIZE)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [FU_SIZE-1:0]            fu_result_valid,
    input  logic                          cdb_stall,
    output logic [CDB_WIDTH-1:0]          cdb_valid,
    output logic [CDB_WIDTH*FU_IDX_W-1:0] cdb_fu_num,
    output logic [CDB_WIDTH*4-1:0]        cdb_cat,
    output logic [FU_SIZE-1:0]            fu_grant
);
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    localparam int MAXN = max2(max2(NUM_ALU, NUM_LS), max2(NUM_MULT, NUM_BEQ));
    localparam int PW = $clog2(MAXN) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int NUMS [4] = '{NUM_ALU, NUM_LS, NUM_MULT, NUM_BEQ};
    localparam int BASE [4] = '{0, NUM_ALU, NUM_ALU + NUM_LS, NUM_ALU + NUM_LS + NUM_MULT};

    logic [PW-1:0]       ptr [4];
    logic [PW-1:0]       ptr_nxt [4];
    logic [SW-1:0]       starve [4];
    logic [3:0]          got, req, boost;
    logic [FU_IDX_W-1:0] num_a [CDB_WIDTH];
    logic [3:0]          cat_a [CDB_WIDTH];
    logic [CDB_WIDTH-1:0] valid_a;
    logic [FU_SIZE-1:0]  grant_a;
    logic                active;
    int                  cnt, loc;

    // Two passes over beq..alu (boosted first, then the rest) build the candidate list.
    always_comb begin
        cnt = 0;
        loc = 0;
        valid_a = '0;
        grant_a = '0;
        got = '0;
        req = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            num_a[k] = '0;
            cat_a[k] = '0;
        end
        for (int c = 0; c < 4; c++) begin
            boost[c] = starve[c] == SW'(STARVE_LIMIT);
            ptr_nxt[c] = ptr[c];
        end
        for (int p = 0; p < 2; p++)
            for (int c = 3; c >= 0; c--)
                if (boost[c] == (p == 0))
                    for (int j = 0; j < MAXN; j++)
                        if (j < NUMS[c]) begin
                            loc = int'(ptr[c]) + j;
                            loc = loc >= NUMS[c] ? loc - NUMS[c] : loc;
                            if (fu_result_valid[BASE[c] + loc]) begin
                                req[c] = 1'b1;
                                if (cnt < CDB_WIDTH) begin
                                    valid_a[cnt] = 1'b1;
                                    num_a[cnt] = FU_IDX_W'(BASE[c] + loc);
                                    cat_a[cnt] = 4'(1 << c);
                                    grant_a[BASE[c] + loc] = 1'b1;
                                    got[c] = 1'b1;
                                    ptr_nxt[c] = PW'(loc + 1 >= NUMS[c] ? 0 : loc + 1);
                                    cnt++;
                                end
                            end
                        end
    end

    assign active = reset && !cdb_stall;

    always_comb begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
            cdb_valid[k] = active & valid_a[k];
            cdb_fu_num[k*FU_IDX_W +: FU_IDX_W] = active ? num_a[k] : '0;
            cdb_cat[k*4 +: 4] = active ? cat_a[k] : 4'b0;
        end
        fu_grant = active ? grant_a : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                ptr[c] <= '0;
                starve[c] <= '0;
            end
        end else if (!cdb_stall) begin
            for (int c = 0; c < 4; c++) begin
                ptr[c] <= ptr_nxt[c];
                starve[c] <= (got[c] || !req[c]) ? '0 :
                             (starve[c] == SW'(STARVE_LIMIT)) ? starve[c] : starve[c] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed-vector bench for cdb_arbiter with default parameters
// (8 ALU, 4 LS, 4 MULT, 4 BEQ, 2 CDB ports, starvation limit 7).
module tb_cdb_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] fu_result_valid = '0;
    logic        cdb_stall = 1'b0;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_fu_num;
    logic [7:0]  cdb_cat;
    logic [19:0] fu_grant;
    int checks = 0;
    int errors = 0;

    localparam logic [19:0] ALU03 = 20'h0000F;
    localparam logic [19:0] MIX = (20'd1 << 1) | (20'd1 << 8) | (20'd1 << 18);
    localparam logic [19:0] STV = (20'd1 << 16) | (20'd1 << 12) | (20'd1 << 5);
    localparam logic [19:0] BB_M = (20'd1 << 16) | (20'd1 << 17) | (20'd1 << 12);
    localparam logic [19:0] G_BM = (20'd1 << 16) | (20'd1 << 12);

    cdb_arbiter dut (
        .clock(clock),
        .reset(reset),
        .fu_result_valid(fu_result_valid),
        .cdb_stall(cdb_stall),
        .cdb_valid(cdb_valid),
        .cdb_fu_num(cdb_fu_num),
        .cdb_cat(cdb_cat),
        .fu_grant(fu_grant)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic [1:0] v, input logic [4:0] f0,
                           input logic [3:0] c0, input logic [4:0] f1, input logic [3:0] c1,
                           input logic [19:0] g);
        chk({tag, ".valid"}, 32'(cdb_valid), 32'(v));
        chk({tag, ".fu_num"}, 32'(cdb_fu_num), 32'({f1, f0}));
        chk({tag, ".cat"}, 32'(cdb_cat), 32'({c1, c0}));
        chk({tag, ".grant"}, 32'(fu_grant), 32'(g));
    endtask

    // Inputs change just after the falling edge; outputs are checked 1 time unit later.
    task automatic drive(input logic r, input logic [19:0] v, input logic s);
        @(negedge clock);
        reset = r;
        fu_result_valid = v;
        cdb_stall = s;
        #1;
    endtask

    initial begin
        drive(1'b0, ALU03, 1'b0);
        drive(1'b0, ALU03, 1'b0);
        exp_out("in_reset", 2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 20'h0);

        drive(1'b1, 20'h0, 1'b0);
        exp_out("idle", 2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 20'h0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rst_ptr%0d", c), 32'(dut.ptr[c]), 32'd0);
            chk($sformatf("rst_starve%0d", c), 32'(dut.starve[c]), 32'd0);
        end

        drive(1'b1, MIX, 1'b0);
        exp_out("mix", 2'b11, 5'd18, 4'b1000, 5'd8, 4'b0010, (20'd1 << 18) | (20'd1 << 8));
        drive(1'b1, 20'h0, 1'b0);
        chk("mix_ptr_beq", 32'(dut.ptr[3]), 32'd3);
        chk("mix_ptr_ls", 32'(dut.ptr[1]), 32'd1);
        chk("mix_starve_alu", 32'(dut.starve[0]), 32'd1);

        drive(1'b0, 20'h0, 1'b0);
        drive(1'b1, ALU03, 1'b0);
        exp_out("rr1", 2'b11, 5'd0, 4'b0001, 5'd1, 4'b0001, 20'h00003);
        drive(1'b1, ALU03, 1'b0);
        exp_out("rr2", 2'b11, 5'd2, 4'b0001, 5'd3, 4'b0001, 20'h0000C);
        drive(1'b1, ALU03, 1'b0);
        exp_out("rr3", 2'b11, 5'd0, 4'b0001, 5'd1, 4'b0001, 20'h00003);

        drive(1'b0, 20'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, STV, 1'b0);
            exp_out($sformatf("stv%0d", i), 2'b11, 5'd16, 4'b1000, 5'd12, 4'b0100, G_BM);
        end
        drive(1'b1, STV, 1'b1);
        exp_out("stall1", 2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 20'h0);
        chk("stall_starve_before", 32'(dut.starve[0]), 32'd3);
        drive(1'b1, STV, 1'b1);
        exp_out("stall2", 2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 20'h0);
        chk("stall_starve_hold", 32'(dut.starve[0]), 32'd3);
        chk("stall_ptr_beq", 32'(dut.ptr[3]), 32'd1);
        chk("stall_ptr_mult", 32'(dut.ptr[2]), 32'd1);
        for (int i = 3; i < 7; i++) begin
            drive(1'b1, STV, 1'b0);
            exp_out($sformatf("stv%0d", i), 2'b11, 5'd16, 4'b1000, 5'd12, 4'b0100, G_BM);
        end
        drive(1'b1, STV, 1'b0);
        chk("boost_starve_alu", 32'(dut.starve[0]), 32'd7);
        exp_out("boost", 2'b11, 5'd5, 4'b0001, 5'd16, 4'b1000, (20'd1 << 5) | (20'd1 << 16));
        drive(1'b1, STV, 1'b0);
        chk("post_starve_alu", 32'(dut.starve[0]), 32'd0);
        chk("post_starve_mult", 32'(dut.starve[2]), 32'd1);
        chk("post_starve_beq", 32'(dut.starve[3]), 32'd0);
        chk("post_ptr_alu", 32'(dut.ptr[0]), 32'd6);
        exp_out("post_boost", 2'b11, 5'd16, 4'b1000, 5'd12, 4'b0100, G_BM);

        drive(1'b0, 20'h0, 1'b0);
        drive(1'b1, 20'h00007, 1'b0);
        exp_out("pre_a", 2'b11, 5'd0, 4'b0001, 5'd1, 4'b0001, 20'h00003);
        drive(1'b1, 20'h00004, 1'b0);
        exp_out("pre_b", 2'b01, 5'd2, 4'b0001, 5'd0, 4'd0, 20'h00004);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, BB_M, 1'b0);
            exp_out($sformatf("bb%0d", i), 2'b11, 5'd16, 4'b1000, 5'd17, 4'b1000, 20'h30000);
        end
        drive(1'b0, ALU03, 1'b0);
        chk("mid_ptr_alu", 32'(dut.ptr[0]), 32'd3);
        chk("mid_starve_mult", 32'(dut.starve[2]), 32'd4);
        exp_out("mid_reset", 2'b00, 5'd0, 4'd0, 5'd0, 4'd0, 20'h0);
        drive(1'b1, ALU03, 1'b0);
        chk("after_ptr_alu", 32'(dut.ptr[0]), 32'd0);
        chk("after_starve_mult", 32'(dut.starve[2]), 32'd0);
        exp_out("after_reset", 2'b11, 5'd0, 4'b0001, 5'd1, 4'b0001, 20'h00003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
